button_debouncer: RTL

//   Conditions the four raw PMOD push-button inputs (already inverted to active-high) before the

---
 rtl/button_debouncer_pkg.sv | 16 +
 rtl/button_debouncer_channel.sv | 96 +++++++++
 rtl/button_debouncer.sv | 63 ++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning block: channel FSM
// state encoding and default sizing for the per-channel millisecond counter.
package btn_pkg;

  // Per-channel debounce state; level is high in HELD and ARM_R.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM_P = 2'd1,
    HELD  = 2'd2,
    ARM_R = 2'd3
  } btn_state_t;

  localparam int unsigned MS_W_DEFAULT        = 8;
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: 2-FF synchroniser followed by a time-based debouncer
// that requires DEBOUNCE_MS millisecond ticks of stable input before it
// accepts a press or a release. Outputs are registered.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  parameter int unsigned MS_W        = MS_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic released
);

  localparam logic [MS_W-1:0] LAST = MS_W'(DEBOUNCE_MS - 1);

  logic [1:0]      sync_ff;
  logic            sync;
  btn_state_t      state;
  logic [MS_W-1:0] cnt;

  assign sync = sync_ff[1];

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
    end
  end

  // Debounce FSM with registered level and single-cycle strobes. A sync
  // change always takes priority over a coincident ms_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= ARM_P;
            cnt   <= '0;
          end
        end
        ARM_P: begin
          if (!sync) begin
            state <= IDLE;
          end else if (ms_tick) begin
            if (cnt == LAST) begin
              state <= HELD;
              level <= 1'b1;
              press <= 1'b1;
            end else if (cnt < LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (!sync) begin
            state <= ARM_R;
            cnt   <= '0;
          end
        end
        ARM_R: begin
          if (sync) begin
            state <= HELD;
          end else if (ms_tick) begin
            if (cnt == LAST) begin
              state    <= IDLE;
              level    <= 1'b0;
              released <= 1'b1;
            end else if (cnt < LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: shared millisecond prescaler feeding NUM_BTN
// independent debounce channels, plus an OR of all press strobes.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  parameter int unsigned TICKS_W     = 16,
  parameter int unsigned MS_W        = MS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TICKS_W-1:0] ticks_per_milli,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  logic [TICKS_W-1:0] pcnt;
  logic [TICKS_W:0]   pcnt_inc;
  logic               ms_tick;

  // Tick when pcnt+1 >= ticks_per_milli; the extra bit keeps values 0 and 1
  // (and runtime decreases) producing an immediate tick without underflow.
  always_comb begin
    pcnt_inc = {1'b0, pcnt} + {{TICKS_W{1'b0}}, 1'b1};
    ms_tick  = (pcnt_inc >= {1'b0, ticks_per_milli});
  end

  // Millisecond prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (ms_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt_inc[TICKS_W-1:0];
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .MS_W       (MS_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ms_tick (ms_tick),
      .raw     (btn_raw[i]),
      .level   (btn_level[i]),
      .press   (btn_press[i]),
      .released(btn_release[i])
    );
  end

  // Any-button press strobe, aligned with the per-button strobes.
  always_comb begin
    any_press = |btn_press;
  end

endmodule
